// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO (registered read) and sends each word as a UART frame.
// Frame format: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
// Compile-time option FIFO_UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe (one-cycle pulse in POP)
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//   tx          serial output, idles high
//   busy        high from POP through the last STOP cycle
//   tx_done     one-cycle pulse on the final cycle of each stop bit
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPop    = 3'd1,
    StLoad   = 3'd2,
    StStart  = 3'd3,
    StData   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    StParity = 3'd5,
`endif
    StStop   = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic                  baud_last;

`ifdef FIFO_UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BaudLast);

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) state_d = StPop;
      end
      StPop: begin
        baud_d  = '0;
        state_d = StLoad;
      end
      StLoad: begin
        shift_d = fifo_rdata;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_rdata;
`endif
        baud_d  = '0;
        bit_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BitLast) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          // Only point besides IDLE where fifo_empty is looked at.
          state_d = fifo_empty ? StIdle : StPop;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered outputs line up with state_q.
  always_comb begin
    tx_d    = 1'b1;
    busy_d  = (state_d != StIdle);
    rd_en_d = (state_d == StPop);
    done_d  = (state_d == StStop) && (baud_d == BaudLast);
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small registered-read FIFO model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FC = 44;  // frame cycles
  localparam int NB = 11;  // bits per frame
`else
  localparam int FC = 40;
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rdata = 8'h00;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: registered read, data valid the cycle after fifo_rd_en.
  logic [7:0] mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr % 16];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  logic cap_tx   [256];
  logic cap_busy [256];
  logic cap_rd   [256];
  logic cap_done [256];

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
      cap_rd[i]   = fifo_rd_en;
      cap_done[i] = tx_done;
    end
  endtask

  task automatic test_reset;
    int bad;
    bad = 0;
    push(8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL reset_hold: %0d bad cycles, expected 0", bad);
    end
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++; $display("FAIL reset_tx: got %b expected 1", tx);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    n_checks++;
    if (rd_ptr !== 0) begin
      n_fail++; $display("FAIL reset_no_pop: rd_ptr %0d expected 0", rd_ptr);
    end
  endtask

  task automatic test_single_byte;
`ifdef FIFO_UART_TX_PARITY_EN
    int exp_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    int exp_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    int rd_cnt, rd_idx, done_cnt, done_idx, start_idx, lows;
    rst = 1'b0;
    capture(FC + 10);
    rd_cnt = 0; rd_idx = -1; done_cnt = 0; done_idx = -1; start_idx = -1; lows = 0;
    for (int i = 0; i < FC + 10; i++) begin
      if (cap_rd[i] === 1'b1) begin rd_cnt++; if (rd_idx < 0) rd_idx = i; end
      if (cap_done[i] === 1'b1) begin done_cnt++; if (done_idx < 0) done_idx = i; end
      if (cap_tx[i] === 1'b0 && start_idx < 0) start_idx = i;
      if (i >= FC + 2 && cap_tx[i] !== 1'b1) lows++;
    end
    n_checks++;
    if (rd_cnt !== 1) begin n_fail++; $display("FAIL single_rd_count: got %0d expected 1", rd_cnt); end
    n_checks++;
    if (rd_idx !== 0) begin n_fail++; $display("FAIL single_rd_idx: got %0d expected 0", rd_idx); end
    n_checks++;
    if (start_idx !== 2) begin
      n_fail++; $display("FAIL single_start_idx: got %0d expected 2", start_idx);
    end
    for (int k = 0; k < NB; k++) begin
      n_checks++;
      if (cap_tx[2 + CPB * k + 2] !== exp_bits[k][0]) begin
        n_fail++;
        $display("FAIL single_bit%0d: got %b expected %0d", k, cap_tx[2 + CPB * k + 2], exp_bits[k]);
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (done_idx - 2 + 1 !== FC) begin
      n_fail++; $display("FAIL single_frame_len: got %0d expected %0d", done_idx - 1, FC);
    end
    n_checks++;
    if (cap_busy[FC + 1] !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_stop: got %b expected 1", cap_busy[FC + 1]);
    end
    n_checks++;
    if (cap_busy[FC + 2] !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_idle: got %b expected 0", cap_busy[FC + 2]);
    end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL single_idle_tx: %0d low cycles expected 0", lows); end
  endtask

  task automatic test_back_to_back;
    int rd_cnt, done_cnt, gap, bad1, bad2;
    push(8'h00);
    push(8'hFF);
    capture(2 * FC + 10);
    rd_cnt = 0; done_cnt = 0; gap = 0; bad1 = 0; bad2 = 0;
    for (int i = 0; i < 2 * FC + 10; i++) begin
      if (cap_rd[i] === 1'b1) rd_cnt++;
      if (cap_done[i] === 1'b1) done_cnt++;
    end
    for (int i = FC + 2; i < FC + 10; i++) begin
      if (cap_tx[i] !== 1'b1) break;
      gap++;
    end
    for (int k = 0; k < 8; k++) begin
      if (cap_tx[8 + CPB * k] !== 1'b0) bad1++;
      if (cap_tx[FC + 10 + CPB * k] !== 1'b1) bad2++;
    end
    n_checks++;
    if (rd_cnt !== 2) begin n_fail++; $display("FAIL b2b_rd_count: got %0d expected 2", rd_cnt); end
    n_checks++;
    if (cap_rd[FC + 2] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rd2_pos: got %b expected 1", cap_rd[FC + 2]);
    end
    n_checks++;
    if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    n_checks++;
    if (cap_done[FC + 1] !== 1'b1 || cap_done[2 * FC + 3] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_pos: got %b/%b expected 1/1", cap_done[FC + 1], cap_done[2 * FC + 3]);
    end
    n_checks++;
    if (gap !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 2", gap); end
    n_checks++;
    if (cap_tx[FC + 4] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start2: got %b expected 0", cap_tx[FC + 4]);
    end
    n_checks++;
    if (bad1 !== 0) begin n_fail++; $display("FAIL b2b_data00: %0d bad bits expected 0", bad1); end
    n_checks++;
    if (bad2 !== 0) begin n_fail++; $display("FAIL b2b_dataff: %0d bad bits expected 0", bad2); end
    n_checks++;
    if (cap_busy[FC + 2] !== 1'b1 || cap_busy[FC + 3] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy_gap: got %b%b expected 11", cap_busy[FC + 2], cap_busy[FC + 3]);
    end
    n_checks++;
    if (cap_busy[2 * FC + 4] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", cap_busy[2 * FC + 4]);
    end
  endtask

  task automatic test_empty_idle;
    int rd_cnt, lows, busy_cnt;
    capture(100);
    rd_cnt = 0; lows = 0; busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (cap_rd[i] !== 1'b0) rd_cnt++;
      if (cap_tx[i] !== 1'b1) lows++;
      if (cap_busy[i] !== 1'b0) busy_cnt++;
    end
    n_checks++;
    if (rd_cnt !== 0) begin n_fail++; $display("FAIL empty_rd: got %0d expected 0", rd_cnt); end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL empty_tx: %0d low cycles expected 0", lows); end
    n_checks++;
    if (busy_cnt !== 0) begin n_fail++; $display("FAIL empty_busy: got %0d expected 0", busy_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    int rd_cnt, lows, busy_cnt;
    push(8'h3C);
    capture(20);  // last sample is mid DATA bit 3
    n_checks++;
    if (cap_tx[12] !== 1'b0) begin n_fail++; $display("FAIL mid_bit1: got %b expected 0", cap_tx[12]); end
    n_checks++;
    if (cap_tx[16] !== 1'b1) begin n_fail++; $display("FAIL mid_bit2: got %b expected 1", cap_tx[16]); end
    n_checks++;
    if (cap_busy[19] !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy_before: got %b expected 1", cap_busy[19]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    capture(60);
    rd_cnt = 0; lows = 0; busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (cap_rd[i] !== 1'b0) rd_cnt++;
      if (cap_tx[i] !== 1'b1) lows++;
      if (cap_busy[i] !== 1'b0) busy_cnt++;
    end
    n_checks++;
    if (rd_cnt !== 0) begin n_fail++; $display("FAIL mid_after_rd: got %0d expected 0", rd_cnt); end
    n_checks++;
    if (lows !== 0) begin n_fail++; $display("FAIL mid_after_tx: %0d low cycles expected 0", lows); end
    n_checks++;
    if (busy_cnt !== 0) begin n_fail++; $display("FAIL mid_after_busy: got %0d expected 0", busy_cnt); end
    n_checks++;
    if (rd_ptr !== wr_ptr) begin
      n_fail++; $display("FAIL mid_pop_total: rd_ptr %0d expected %0d", rd_ptr, wr_ptr);
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] bytes [2] = '{8'hA5, 8'h07};
    logic       par   [2] = '{1'b0, 1'b1};
    int done_idx;
    for (int t = 0; t < 2; t++) begin
      push(bytes[t]);
      capture(FC + 10);
      done_idx = -1;
      for (int i = 0; i < FC + 10; i++) if (cap_done[i] === 1'b1 && done_idx < 0) done_idx = i;
      n_checks++;
      if (cap_tx[2 + CPB * 9 + 2] !== par[t]) begin
        n_fail++;
        $display("FAIL parity_bit%0d: got %b expected %b", t, cap_tx[2 + CPB * 9 + 2], par[t]);
      end
      n_checks++;
      if (done_idx - 1 !== 44) begin
        n_fail++; $display("FAIL parity_len%0d: got %0d expected 44", t, done_idx - 1);
      end
      n_checks++;
      if (cap_tx[2 + CPB * 10 + 2] !== 1'b1) begin
        n_fail++; $display("FAIL parity_stop%0d: got %b expected 1", t, cap_tx[2 + CPB * 10 + 2]);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_empty_idle();
    test_reset_mid_frame();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
